// File: rtl/bufram256_wr.sv
// Transposing 2x256 complex double buffer: writes each frame in 16x16-transposed order and reads it out linearly.
// Latency: one ED cycle from read address to DOR/DOI; RDY appears one clock after the first read of a complete frame.
// No backpressure: accepts one sample per ED cycle, START restarts the frame, BUFRAM256_FCNT_EN adds the FCNT frame counter.
module bufram256_wr #(
    parameter int nb = 12
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ED,
    input  logic          START,
    input  logic [nb-1:0] DR,
    input  logic [nb-1:0] DI,
    output logic          RDY,
    output logic [nb-1:0] DOR,
    output logic [nb-1:0] DOI
`ifdef BUFRAM256_FCNT_EN
    ,
    output logic [7:0]    FCNT
`endif
);

    // cnt[8] selects the bank being written, cnt[7:0] is the sample index within it
    logic [8:0]      cnt;
    logic            full;
    logic [2*nb-1:0] mem [0:511];

    logic            adv;
    logic [8:0]      wr_addr;
    logic [8:0]      rd_addr;
    logic            rdy_set;
    logic [2*nb-1:0] rd_word;

    // The sample is only taken on enabled cycles; a START cycle discards its sample
    assign adv     = ED & ~START;
    // Writing at the nibble-swapped index turns the linear read of the other bank into a 16x16 transpose
    assign wr_addr = {cnt[8], cnt[3:0], cnt[7:4]};
    assign rd_addr = {~cnt[8], cnt[7:0]};
    // Index 0 of the other bank is only meaningful once a whole bank has been written since START/reset
    assign rdy_set = adv & full & (cnt[7:0] == 8'd0);
    assign rd_word = mem[rd_addr];

    // Sample storage; contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (adv) begin
            mem[wr_addr] <= {DR, DI};
        end
    end

    // Counter, frame-complete flag, frame marker and registered read data
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt  <= 9'd0;
            full <= 1'b0;
            RDY  <= 1'b0;
            DOR  <= '0;
            DOI  <= '0;
        end else begin
            RDY <= rdy_set;
            if (START) begin
                cnt  <= 9'd0;
                full <= 1'b0;
            end else if (ED) begin
                cnt <= cnt + 9'd1;
                if (cnt == 9'd255) begin
                    full <= 1'b1;
                end
                DOR <= rd_word[2*nb-1:nb];
                DOI <= rd_word[nb-1:0];
            end
        end
    end

`ifdef BUFRAM256_FCNT_EN
    // Completed-frame counter advances with every RDY pulse and survives START
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            FCNT <= 8'd0;
        end else if (rdy_set) begin
            FCNT <= FCNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bufram256_wr.sv
module tb_bufram256_wr;
    localparam int NB = 12;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ED;
    logic          START;
    logic [NB-1:0] DR;
    logic [NB-1:0] DI;
    logic          RDY;
    logic [NB-1:0] DOR;
    logic [NB-1:0] DOI;
`ifdef BUFRAM256_FCNT_EN
    logic [7:0]    FCNT;
    logic [7:0]    fcnt_exp;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bufram256_wr #(.nb(NB)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .ED    (ED),
        .START (START),
        .DR    (DR),
        .DI    (DI),
        .RDY   (RDY),
        .DOR   (DOR),
        .DOI   (DOI)
`ifdef BUFRAM256_FCNT_EN
        ,
        .FCNT  (FCNT)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc = cyc + 1;

    typedef struct {
        logic          rst;
        logic          start;
        logic          ed;
        logic [NB-1:0] dr;
        logic [NB-1:0] di;
        logic          chk_d;
        logic          exp_rdy;
        logic [NB-1:0] exp_dor;
        logic [NB-1:0] exp_doi;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Apply inputs just after an edge, clock once, then sample 1ns after the edge
    task automatic step(input logic st, input logic ed, input logic [NB-1:0] dr, input logic [NB-1:0] di);
        START = st;
        ED    = ed;
        DR    = dr;
        DI    = di;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input string tag);
        step(1'b1, 1'b1, 12'hABC, 12'h543);
        check({tag, " start_rdy"}, {31'd0, RDY}, 32'd0);
`ifdef BUFRAM256_FCNT_EN
        check({tag, " start_fcnt"}, {24'd0, FCNT}, {24'd0, fcnt_exp});
`endif
    endtask

    // Sample number appearing after the k-th ED cycle (k>=257) when input n = k-1
    function automatic int exp_n(input int k);
        int f;
        int j;
        f = (k - 257) / 256;
        j = (k - 257) % 256;
        return 256 * f + 16 * (j % 16) + j / 16;
    endfunction

    // Feed nsamp samples DR=n, DI=~n; optionally insert an ED=0 cycle after each one
    task automatic run_stream(input int nsamp, input bit toggle, input string tag);
        int            last_rdy;
        int            en;
        logic [NB-1:0] n;
        logic [NB-1:0] ni;
        logic [NB-1:0] ev;
        logic [NB-1:0] evi;
        logic          er;
        last_rdy = -1;
        ev  = '0;
        evi = '0;
        for (int k = 1; k <= nsamp; k++) begin
            n  = NB'(k - 1);
            ni = ~n;
            step(1'b0, 1'b1, n, ni);
            er = (k >= 257) && (((k - 257) % 256) == 0);
            check({tag, " rdy"}, {31'd0, RDY}, {31'd0, er});
`ifdef BUFRAM256_FCNT_EN
            if (er) fcnt_exp = fcnt_exp + 8'd1;
            check({tag, " fcnt"}, {24'd0, FCNT}, {24'd0, fcnt_exp});
`endif
            if (RDY === 1'b1) begin
                if (last_rdy >= 0)
                    check({tag, " rdy_spacing"}, cyc - last_rdy, toggle ? 32'd512 : 32'd256);
                last_rdy = cyc;
            end
            if (k >= 257) begin
                en  = exp_n(k);
                ev  = en[NB-1:0];
                evi = ~ev;
                check({tag, " dor"}, {20'd0, DOR}, {20'd0, ev});
                check({tag, " doi"}, {20'd0, DOI}, {20'd0, evi});
            end
            if (toggle) begin
                step(1'b0, 1'b0, ni, n);
                check({tag, " idle_rdy"}, {31'd0, RDY}, 32'd0);
                if (k >= 257) begin
                    check({tag, " hold_dor"}, {20'd0, DOR}, {20'd0, ev});
                    check({tag, " hold_doi"}, {20'd0, DOI}, {20'd0, evi});
                end
            end
        end
    endtask

    initial begin
        RST   = 1'b0;
        ED    = 1'b0;
        START = 1'b0;
        DR    = '0;
        DI    = '0;
`ifdef BUFRAM256_FCNT_EN
        fcnt_exp = 8'd0;
`endif
        //            rst   start ed    dr      di      chk_d exp_rdy dor  doi
        tbl[0] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, '0, '0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 12'h5A5, 12'hA5A, 1'b1, 1'b0, '0, '0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 12'h123, 12'h321, 1'b1, 1'b0, '0, '0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 12'h777, 12'h888, 1'b0, 1'b0, '0, '0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, '0, '0};

        for (int i = 0; i < 5; i++) begin
            RST = tbl[i].rst;
            step(tbl[i].start, tbl[i].ed, tbl[i].dr, tbl[i].di);
            check($sformatf("vec%0d rdy", i), {31'd0, RDY}, {31'd0, tbl[i].exp_rdy});
            if (tbl[i].chk_d) begin
                check($sformatf("vec%0d dor", i), {20'd0, DOR}, {20'd0, tbl[i].exp_dor});
                check($sformatf("vec%0d doi", i), {20'd0, DOI}, {20'd0, tbl[i].exp_doi});
            end
        end

        // Continuous stream over three frames: two reordered output frames and the bank switch
        do_start("cont");
        run_stream(768, 1'b0, "cont");

        // ED alternating 1/0 over two frames plus the next RDY
        do_start("tog");
        run_stream(513, 1'b1, "tog");

        // Partial frame abandoned by a second START
        do_start("abort");
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, NB'(1000 + i), NB'(2000 + i));
            check("abort partial_rdy", {31'd0, RDY}, 32'd0);
        end
        do_start("abort2");
        run_stream(300, 1'b0, "abort");

        // Asynchronous reset landing on the RDY cycle, between clock edges
        do_start("rst");
        run_stream(257, 1'b0, "rst");
        #3;
        RST = 1'b0;
        #1;
`ifdef BUFRAM256_FCNT_EN
        fcnt_exp = 8'd0;
        check("async fcnt", {24'd0, FCNT}, 32'd0);
`endif
        check("async rdy", {31'd0, RDY}, 32'd0);
        check("async dor", {20'd0, DOR}, 32'd0);
        check("async doi", {20'd0, DOI}, 32'd0);
        ED = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        do_start("post");
        run_stream(512, 1'b0, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
